// File: rtl/controlled_countdown_pkg.sv
// Shared definitions for the countdown engine: default width and FSM state encodings.
package controlled_countdown_pkg;

  localparam int CD_WIDTH = 8;

  typedef enum logic [1:0] {
    CD_IDLE = 2'd0,
    CD_RUN  = 2'd1,
    CD_DONE = 2'd2
  } cd_state_t;

endpackage

// File: rtl/controlled_countdown_if.sv
// Load handshake, control strobes and status outputs of the countdown engine.
interface controlled_countdown_if #(parameter int WIDTH = controlled_countdown_pkg::CD_WIDTH);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             dec_en;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, dec_en, auto_reload, abort,
    input  load_ready, count, zero, busy, done
  );

  modport slave (
    input  load_valid, load_value, dec_en, auto_reload, abort,
    output load_ready, count, zero, busy, done
  );

endinterface

// File: rtl/ControlledDecrementor.sv
// Ripple-borrow controlled decrementor: Out = A ? Z-1 : Z, Bout is the borrow out of the MSB.
module ControlledDecrementor #(
  parameter int WIDTH = 8
) (
  input  logic             A,
  input  logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Out,
  output logic             Bout
);

  logic [WIDTH:0] borrow;

  // borrow[0] is the enable, so bit 0 is a half subtractor and the rest are full subtractors.
  always_comb begin
    borrow    = '0;
    Out       = '0;
    borrow[0] = A;
    for (int i = 0; i < WIDTH; i++) begin
      Out[i]      = Z[i] ^ borrow[i];
      borrow[i+1] = ~Z[i] & borrow[i];
    end
    Bout = borrow[WIDTH];
  end

endmodule

// File: rtl/controlled_countdown.sv
// Countdown engine: load over valid/ready, decrement on dec_en, one-cycle done, optional auto-reload.
//   state | meaning
//   IDLE  | waiting for a load, load_ready high
//   RUN   | counting down, busy high
//   DONE  | count reached zero, done high for this single cycle
module controlled_countdown
  import controlled_countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  controlled_countdown_if.slave  bus
);

  cd_state_t        state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] dec_out;
  logic             dec_borrow;
  logic             dec_act;

  assign dec_act = (state == CD_RUN) && bus.dec_en;

  ControlledDecrementor #(.WIDTH(WIDTH)) u_dec (
    .A    (dec_act),
    .Z    (count),
    .Out  (dec_out),
    .Bout (dec_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CD_IDLE;
      count      <= '0;
      reload_reg <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    case (state)
      CD_IDLE: begin
        if (bus.load_valid) begin
          count_nxt  = bus.load_value;
          reload_nxt = bus.load_value;
          state_nxt  = (bus.load_value != '0) ? CD_RUN : CD_DONE;
        end
      end
      CD_RUN: begin
        if (bus.abort) begin
          state_nxt = CD_IDLE;
        end else if (bus.dec_en) begin
          count_nxt = dec_out;
          // A borrow can only come from an illegal zero count in RUN; finish rather than wrap forever.
          if (dec_out == '0 || dec_borrow) state_nxt = CD_DONE;
        end
      end
      CD_DONE: begin
        if (bus.auto_reload && reload_reg != '0) begin
          count_nxt = reload_reg;
          state_nxt = CD_RUN;
        end else begin
          count_nxt = '0;
          state_nxt = CD_IDLE;
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = CD_IDLE;
      end
    endcase
  end

  assign bus.load_ready = (state == CD_IDLE);
  assign bus.busy       = (state == CD_RUN);
  assign bus.done       = (state == CD_DONE);
  assign bus.count      = count;
  assign bus.zero       = (count == '0);

endmodule
